// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: registers one EX result and runs loads/stores over a
// request/grant/response SRAM handshake, with alignment/timeout checks and forwarding.
module mem_lsu_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int PC_W    = 32,
  parameter int RF_AW   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W-1:0]   in_ex_result,
  input  logic                in_rf_we,
  input  logic [RF_AW-1:0]    in_rf_waddr,
  output logic                dreq,
  output logic                dwe,
  output logic [ADDR_W-1:0]   daddr,
  output logic [DATA_W/8-1:0] dbe,
  output logic [DATA_W-1:0]   dwdata,
  input  logic                dgnt,
  input  logic                drvalid,
  input  logic [DATA_W-1:0]   drdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [PC_W-1:0]     wb_pc,
  output logic                wb_rf_we,
  output logic [RF_AW-1:0]    wb_rf_waddr,
  output logic [DATA_W-1:0]   wb_rf_wdata,
  output logic [1:0]          wb_excp,
  output logic                fwd_we,
  output logic [RF_AW-1:0]    fwd_waddr,
  output logic [DATA_W-1:0]   fwd_wdata,
  output logic                fwd_load_pending
);
  localparam int NB    = DATA_W / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SH8   = DATA_W - 8;
  localparam int SH16  = DATA_W - 16;
  localparam int SH32  = DATA_W - 32;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4, OP_LW = 4'd5, OP_LWU = 4'd6, OP_LD = 4'd7;
  localparam logic [3:0] OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10, OP_SD = 4'd11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [3:0]          op_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   result_reg;
  logic                rf_we_reg;
  logic [RF_AW-1:0]    waddr_reg;
  logic [1:0]          excp_reg;

  // 64-bit-only opcodes and unused encodings collapse to NONE at capture.
  function automatic logic [3:0] legal_op(input logic [3:0] op);
    if (op > OP_SD) return OP_NONE;
    if (DATA_W != 64 && (op == OP_LWU || op == OP_LD || op == OP_SD)) return OP_NONE;
    return op;
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LD);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SD);
  endfunction

  logic [3:0] cap_op;
  logic       cap_mis;
  logic       cap_mem;

  assign cap_op  = legal_op(in_op);
  assign cap_mem = (cap_op != OP_NONE);

  always_comb begin
    cap_mis = 1'b0;
    case (cap_op)
      OP_LH, OP_LHU, OP_SH: cap_mis = in_addr[0];
      OP_LW, OP_LWU, OP_SW: cap_mis = |in_addr[1:0];
      OP_LD, OP_SD:         cap_mis = |in_addr[2:0];
      default:              cap_mis = 1'b0;
    endcase
  end

  logic [OFFW-1:0]   off;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] ld_data;

  assign off  = addr_reg[OFFW-1:0];
  assign lane = drdata >> {off, 3'b000};

  // Shift the lane to the top and back down to get sign or zero extension.
  always_comb begin
    ld_data = lane;
    case (op_reg)
      OP_LB:   ld_data = $signed(lane << SH8) >>> SH8;
      OP_LBU:  ld_data = (lane << SH8) >> SH8;
      OP_LH:   ld_data = $signed(lane << SH16) >>> SH16;
      OP_LHU:  ld_data = (lane << SH16) >> SH16;
      OP_LW:   ld_data = $signed(lane << SH32) >>> SH32;
      OP_LWU:  ld_data = (lane << SH32) >> SH32;
      default: ld_data = lane;
    endcase
  end

  always_comb begin
    dbe    = '0;
    dwdata = '0;
    case (op_reg)
      OP_SB: begin dwdata = {NB{wdata_reg[7:0]}};        dbe = NB'(1) << off;    end
      OP_SH: begin dwdata = {(NB/2){wdata_reg[15:0]}};   dbe = NB'(3) << off;    end
      OP_SW: begin dwdata = {(NB/4){wdata_reg[31:0]}};   dbe = NB'(4'hF) << off; end
      OP_SD: begin dwdata = wdata_reg;                   dbe = '1;               end
      default: if (is_load(op_reg)) dbe = '1;
    endcase
  end

  assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && wb_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= OP_NONE;
      pc_reg     <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      result_reg <= '0;
      rf_we_reg  <= 1'b0;
      waddr_reg  <= '0;
      excp_reg   <= 2'd0;
    end else begin
      case (state_reg)
        REQ: if (dgnt) begin
          state_reg <= is_load(op_reg) ? WAIT_R : DONE;
          cnt_reg   <= '0;
        end
        WAIT_R: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (drvalid) begin
            result_reg <= ld_data;
            state_reg  <= DONE;
          end else if (TIMEOUT != 0 && cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            excp_reg   <= 2'd2;
            rf_we_reg  <= 1'b0;
            result_reg <= '0;
            state_reg  <= DONE;
          end
        end
        DONE: if (wb_ready) state_reg <= IDLE;
        default: ;
      endcase
      if (in_valid && in_ready) begin
        op_reg     <= cap_op;
        pc_reg     <= in_pc;
        addr_reg   <= in_addr;
        wdata_reg  <= in_wdata;
        waddr_reg  <= in_rf_waddr;
        rf_we_reg  <= in_rf_we && !cap_mis;
        excp_reg   <= cap_mis ? 2'd1 : 2'd0;
        result_reg <= (cap_mis || is_load(cap_op)) ? '0 : in_ex_result;
        cnt_reg    <= '0;
        state_reg  <= (cap_mem && !cap_mis) ? REQ : DONE;
      end
    end
  end

  assign dreq             = (state_reg == REQ);
  assign dwe              = is_store(op_reg);
  assign daddr            = {addr_reg[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign wb_valid         = (state_reg == DONE);
  assign wb_pc            = pc_reg;
  assign wb_rf_we         = rf_we_reg;
  assign wb_rf_waddr      = waddr_reg;
  assign wb_rf_wdata      = result_reg;
  assign wb_excp          = excp_reg;
  assign fwd_we           = (state_reg != IDLE) && rf_we_reg &&
                            (!is_load(op_reg) || state_reg == DONE);
  assign fwd_waddr        = waddr_reg;
  assign fwd_wdata        = result_reg;
  assign fwd_load_pending = (state_reg != IDLE) && is_load(op_reg) && (state_reg != DONE);
endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
Parametrised successor of the MEM pipeline stage. It sits between EX and WB, registers one EX result, and performs loads and stores over a request/grant/response data-SRAM handshake that can take several cycles. It generates aligned addresses, byte enables and lane-replicated store data, and formats load data by address offset with sign or zero extension. It flags misaligned accesses and response timeouts, and drives a forwarding bus to ID that also reports a pending-load hazard.

Parameters:
DATA_W, 32, data/SRAM width; 32 or 64; OFFW = log2(DATA_W/8)
ADDR_W, 32, address width
PC_W, 32, PC width
RF_AW, 5, register-file address width
TIMEOUT, 255, max cycles in WAIT_R before bus error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (rst==0 resets on posedge clk)
in_valid  in  1  EX presents an entry
in_ready  out  1  stage can accept
in_pc  in  PC_W  instruction PC
in_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD, 8 SB, 9 SH, 10 SW, 11 SD; 6/7/11 legal only if DATA_W==64, else treated as NONE
in_addr  in  ADDR_W  effective address
in_wdata  in  DATA_W  store data (low bits used)
in_ex_result  in  DATA_W  ALU result
in_rf_we  in  1  writes register file
in_rf_waddr  in  RF_AW  destination register
dreq  out  1  SRAM request
dwe  out  1  1 store, 0 load
daddr  out  ADDR_W  in_addr with low OFFW bits zeroed
dbe  out  DATA_W/8  byte enables (store); all ones for load
dwdata  out  DATA_W  replicated store data
dgnt  in  1  request accepted
drvalid  in  1  load data valid
drdata  in  DATA_W  load data
wb_valid  out  1  result available
wb_ready  in  1  WB accepts
wb_pc  out  PC_W
wb_rf_we  out  1
wb_rf_waddr  out  RF_AW
wb_rf_wdata  out  DATA_W
wb_excp  out  2  0 none, 1 misaligned, 2 bus timeout
fwd_we  out  1  forwarding valid
fwd_waddr  out  RF_AW
fwd_wdata  out  DATA_W
fwd_load_pending  out  1  valid load whose data is not yet available; ID must stall on match

Behaviour:
- FSM states: IDLE, REQ, WAIT_R, DONE. An entry is captured when in_valid && in_ready. in_ready = (IDLE) || (DONE && wb_ready).
- On capture: NONE or misaligned goes to DONE; a memory op goes to REQ. Misaligned means LH/LHU/SH with addr[0]!=0, LW/LWU/SW with addr[1:0]!=0, or LD/SD with addr[2:0]!=0. A misaligned entry sets wb_excp=1, forces wb_rf_we=0 and never asserts dreq.
- REQ: dreq=1 with stable dwe/daddr/dbe/dwdata until dgnt. On dgnt a store goes to DONE and a load goes to WAIT_R. dgnt outside REQ is ignored.
- WAIT_R: on drvalid, capture the formatted load data and go to DONE. The counter increments each WAIT_R cycle. If TIMEOUT!=0 and counter==TIMEOUT with no drvalid, go to DONE with wb_excp=2 and wb_rf_we=0. drvalid outside WAIT_R is ignored.
- DONE: wb_valid=1. On wb_ready, go to IDLE, or capture the next entry in the same edge.
- Latency from capture edge N:
  - NONE: wb_valid from cycle N+1.
  - Store with dgnt in first REQ cycle: DONE at N+2.
  - Load with immediate dgnt and drvalid one cycle later: DONE at N+3.
- Store formatting:
  - Byte: dwdata = wdata[7:0] replicated, dbe = 1<<off.
  - Half: dwdata = wdata[15:0] replicated, dbe = 2'b11<<off.
  - Word: dwdata = wdata[31:0] replicated, dbe = 4'hF<<off.
  - Double: dbe all ones.
- Load formatting: lane = drdata >> (8*off), where off = addr[OFFW-1:0]. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend to DATA_W.
- wb_rf_wdata = formatted load data for loads, in_ex_result otherwise; it is 0 when wb_rf_we=0 due to an exception.
- Forwarding:
  - fwd_we = stage holds a valid entry && its rf_we && (not a load || DONE).
  - fwd_waddr/fwd_wdata mirror the wb values.
  - fwd_load_pending = valid load entry && state!=DONE.
- Reset (rst==0 at an edge, including mid-transaction): state=IDLE, counter=0, all stored fields 0. Outputs after reset: dreq=0, wb_valid=0, wb_excp=0, fwd_we=0, fwd_load_pending=0, in_ready=1, all data/address outputs 0. Responses arriving after reset are ignored.

Test Plan:
- NONE op, ex_result=0x1234, rf_we=1, waddr=5, wb_ready=1 -> wb_valid one cycle after capture, wb_rf_wdata=0x1234; fwd_we=1, fwd_waddr=5 in the same cycle.
- SB, addr=0x1003, wdata=0xAB, dgnt delayed 3 cycles -> dreq held 3 cycles with daddr=0x1000, dbe=4'b1000, dwdata=0xABABABAB; DONE after dgnt; wb_rf_we=0.
- LB, addr=0x2002, drdata=0x00807F00 -> wb_rf_wdata=0xFFFFFF80. Same with LBU -> 0x00000080. LH at 0x2002 -> 0x00000080. fwd_load_pending=1 until DONE.
- LW, addr=0x2001 -> no dreq, wb_excp=1, wb_rf_we=0; next entry accepted normally.
- LW with TIMEOUT=4 and no drvalid -> wb_excp=2 after 4 WAIT_R cycles; a late drvalid is ignored.
- Reset mid-REQ with dreq=1 -> dreq=0 next cycle, in_ready=1, wb_valid=0. Back-to-back NONE ops with wb_ready=1 give wb_valid on consecutive cycles.
